// File: rtl/id_operand_reader.sv
// id_operand_reader: ID-stage read side of the GRF.
//   - Drives GRF read addresses straight from the ID source indices.
//   - Selects each operand from MEM (non-load) or WB bypass, else the GRF read data.
//   - Raises stall when a used source depends on an EX producer (no EX bypass
//     path exists) or on a load still in MEM.
//   - Owns the ID/EX pipeline register and a saturating stalled-cycle counter.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   id_*                      : decoded ID instruction fields
//   flush                     : kill the ID instruction
//   grf_a1/a2, grf_rd1/rd2    : GRF read port (addresses out, data in)
//   mem_*, wb_*               : MEM and WB producers (WB is the GRF write port)
//   stall                     : combinational hold request for PC and IF/ID
//   ex_*                      : registered ID/EX pipeline outputs
//   stall_cycles              : saturating count of stalled cycles
module id_operand_reader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [ADDR_W-1:0] id_dst,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic [31:0]       id_pc,
  input  logic              flush,
  output logic [ADDR_W-1:0] grf_a1,
  output logic [ADDR_W-1:0] grf_a2,
  input  logic [DATA_W-1:0] grf_rd1,
  input  logic [DATA_W-1:0] grf_rd2,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_dst,
  input  logic              mem_is_load,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_wen,
  input  logic [ADDR_W-1:0] wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_wen,
  output logic              ex_is_load,
  output logic [ADDR_W-1:0] ex_dst,
  output logic [31:0]       ex_pc,
  output logic [DATA_W-1:0] ex_rs_val,
  output logic [DATA_W-1:0] ex_rt_val,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned PC_W = 32;

  logic              ex_valid_q,   ex_valid_d;
  logic              ex_wen_q,     ex_wen_d;
  logic              ex_is_load_q, ex_is_load_d;
  logic [ADDR_W-1:0] ex_dst_q,     ex_dst_d;
  logic [PC_W-1:0]   ex_pc_q,      ex_pc_d;
  logic [DATA_W-1:0] ex_rs_val_q,  ex_rs_val_d;
  logic [DATA_W-1:0] ex_rt_val_q,  ex_rt_val_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic [DATA_W-1:0] rs_val_c, rt_val_c;
  logic              hazard_rs_c, hazard_rt_c;

  // Bypass priority: $0 is constant zero, then MEM (loads excluded), then WB, then GRF.
  function automatic logic [DATA_W-1:0] sel_operand(
    input logic [ADDR_W-1:0] src,
    input logic [DATA_W-1:0] grf_val,
    input logic              m_wen,
    input logic [ADDR_W-1:0] m_dst,
    input logic              m_load,
    input logic [DATA_W-1:0] m_data,
    input logic              w_wen,
    input logic [ADDR_W-1:0] w_dst,
    input logic [DATA_W-1:0] w_data
  );
    logic [DATA_W-1:0] val;
    val = grf_val;
    if (src == '0)                                val = '0;
    else if (m_wen && (m_dst == src) && !m_load) val = m_data;
    else if (w_wen && (w_dst == src))            val = w_data;
    return val;
  endfunction

  // A used, non-zero source waits on any EX producer or on a load sitting in MEM.
  function automatic logic src_hazard(
    input logic              used,
    input logic [ADDR_W-1:0] src,
    input logic              e_valid,
    input logic              e_wen,
    input logic [ADDR_W-1:0] e_dst,
    input logic              m_wen,
    input logic [ADDR_W-1:0] m_dst,
    input logic              m_load
  );
    return used && (src != '0) &&
           ((e_valid && e_wen && (e_dst == src)) ||
            (m_wen && (m_dst == src) && m_load));
  endfunction

  assign grf_a1 = id_rs;
  assign grf_a2 = id_rt;

  // Operand selection and hazard detection.
  always_comb begin
    rs_val_c    = sel_operand(id_rs, grf_rd1, mem_wen, mem_dst, mem_is_load, mem_data,
                              wb_wen, wb_dst, wb_data);
    rt_val_c    = sel_operand(id_rt, grf_rd2, mem_wen, mem_dst, mem_is_load, mem_data,
                              wb_wen, wb_dst, wb_data);
    hazard_rs_c = src_hazard(id_rs_used, id_rs, ex_valid_q, ex_wen_q, ex_dst_q,
                             mem_wen, mem_dst, mem_is_load);
    hazard_rt_c = src_hazard(id_rt_used, id_rt, ex_valid_q, ex_wen_q, ex_dst_q,
                             mem_wen, mem_dst, mem_is_load);
  end

  // Flush overrides a hazard so a killed instruction never holds the front end.
  assign stall = id_valid && !flush && (hazard_rs_c || hazard_rt_c);

  // ID/EX next state: bubble on flush or stall, otherwise capture the ID instruction.
  always_comb begin
    ex_valid_d     = 1'b0;
    ex_wen_d       = 1'b0;
    ex_is_load_d   = 1'b0;
    ex_dst_d       = '0;
    ex_pc_d        = '0;
    ex_rs_val_d    = '0;
    ex_rt_val_d    = '0;
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (!flush && !stall) begin
      ex_valid_d   = id_valid;
      ex_wen_d     = id_wen && id_valid;
      ex_is_load_d = id_is_load;
      ex_dst_d     = id_dst;
      ex_pc_d      = id_pc;
      ex_rs_val_d  = rs_val_c;
      ex_rt_val_d  = rt_val_c;
    end
  end

  // ID/EX pipeline register and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_wen_q       <= 1'b0;
      ex_is_load_q   <= 1'b0;
      ex_dst_q       <= '0;
      ex_pc_q        <= '0;
      ex_rs_val_q    <= '0;
      ex_rt_val_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_wen_q       <= ex_wen_d;
      ex_is_load_q   <= ex_is_load_d;
      ex_dst_q       <= ex_dst_d;
      ex_pc_q        <= ex_pc_d;
      ex_rs_val_q    <= ex_rs_val_d;
      ex_rt_val_q    <= ex_rt_val_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_wen       = ex_wen_q;
  assign ex_is_load   = ex_is_load_q;
  assign ex_dst       = ex_dst_q;
  assign ex_pc        = ex_pc_q;
  assign ex_rs_val    = ex_rs_val_q;
  assign ex_rt_val    = ex_rt_val_q;
  assign stall_cycles = stall_cycles_q;

endmodule
